// File: rtl/rf_tx_serializer.sv
// Serial RF transmitter: captures a DATA_WIDTH payload on a synchronised start edge and shifts it out MSB-first in NRZ or Manchester.
// Define RF_TX_PREAMBLE_EN to prepend an 8-bit 0xAA preamble (state PRE); without it IDLE goes straight to DATA.
module rf_tx_serializer #(
    parameter int BIT_CYCLES = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rf_tx_start,
    input  logic                  rf_tx_mode,
    input  logic                  rf_power_domain,
    input  logic [DATA_WIDTH-1:0] rf_tx_data,
    output logic                  rf_tx_done,
    output logic                  tx_out,
    output logic                  tx_en,
    output logic                  tx_busy,
    output logic [1:0]            dbg_state_o
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int PW = $clog2(BIT_CYCLES);
    localparam logic [PW-1:0] LAST_CYC = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0] HALF_CYC = PW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef RF_TX_PREAMBLE_EN
        PRE  = 2'd1,
`endif
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    logic start_meta_q, start_s_q, start_prev_q;
    logic pwr_meta_q, pwr_s_q;
    logic [1:0] vld_q;
    logic start_rise;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  mode_q, mode_d;
    logic [PW-1:0]         cyc_q, cyc_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
`ifdef RF_TX_PREAMBLE_EN
    logic [2:0]            pre_cnt_q, pre_cnt_d;
`endif
    logic                  line_bit;
    logic                  on_line;

    // start_prev_q resets high and only tracks start_s once the synchroniser holds
    // real samples, so a start held through reset never looks like a rising edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_meta_q <= 1'b0;
            start_s_q    <= 1'b0;
            pwr_meta_q   <= 1'b0;
            pwr_s_q      <= 1'b0;
            vld_q        <= 2'b00;
            start_prev_q <= 1'b1;
        end else begin
            start_meta_q <= rf_tx_start;
            start_s_q    <= start_meta_q;
            pwr_meta_q   <= rf_power_domain;
            pwr_s_q      <= pwr_meta_q;
            vld_q        <= {vld_q[0], 1'b1};
            if (vld_q[1]) begin
                start_prev_q <= start_s_q;
            end
        end
    end

    assign start_rise = start_s_q & ~start_prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            mode_q    <= 1'b0;
            cyc_q     <= '0;
            bit_cnt_q <= '0;
`ifdef RF_TX_PREAMBLE_EN
            pre_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            mode_q    <= mode_d;
            cyc_q     <= cyc_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef RF_TX_PREAMBLE_EN
            pre_cnt_q <= pre_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        mode_d    = mode_q;
        cyc_d     = cyc_q;
        bit_cnt_d = bit_cnt_q;
`ifdef RF_TX_PREAMBLE_EN
        pre_cnt_d = pre_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_rise && pwr_s_q) begin
                    shift_d   = rf_tx_data;
                    mode_d    = rf_tx_mode;
                    cyc_d     = '0;
                    bit_cnt_d = '0;
`ifdef RF_TX_PREAMBLE_EN
                    pre_cnt_d = '0;
                    state_d   = PRE;
`else
                    state_d   = DATA;
`endif
                end
            end
`ifdef RF_TX_PREAMBLE_EN
            PRE: begin
                if (!pwr_s_q) begin
                    state_d = IDLE;
                end else if (cyc_q == LAST_CYC) begin
                    cyc_d = '0;
                    if (pre_cnt_q == 3'd7) begin
                        state_d = DATA;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + PW'(1);
                end
            end
`endif
            DATA: begin
                if (!pwr_s_q) begin
                    state_d = IDLE;
                end else if (cyc_q == LAST_CYC) begin
                    cyc_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        shift_d   = shift_q << 1;
                    end
                end else begin
                    cyc_d = cyc_q + PW'(1);
                end
            end
            DONE: begin
                if (!pwr_s_q || !start_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // 0xAA read MSB-first alternates 1,0,... so the preamble bit is the inverted count LSB.
`ifdef RF_TX_PREAMBLE_EN
    assign line_bit = (state_q == PRE) ? ~pre_cnt_q[0] : shift_q[DATA_WIDTH-1];
    assign on_line  = (state_q == PRE) || (state_q == DATA);
`else
    assign line_bit = shift_q[DATA_WIDTH-1];
    assign on_line  = (state_q == DATA);
`endif

    assign tx_en       = on_line;
    assign tx_out      = on_line & (mode_q ? ((cyc_q < HALF_CYC) ? ~line_bit : line_bit) : line_bit);
    assign tx_busy     = (state_q != IDLE);
    assign rf_tx_done  = (state_q == DONE);
    assign dbg_state_o = state_q;
endmodule

// File: doc/rf_tx_serializer.md
RF_TX_SERIALIZER -- requirements
Module: rf_tx_serializer

Interface
REQ-001 SHALL provide parameter BIT_CYCLES, default 4, clk cycles per transmitted bit; legal values are even and at least 2.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, payload width in bits.
REQ-003 SHALL have port clk  input  1  single block clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rf_tx_start  input  1  level request from the SPI register domain, asynchronous to clk.
REQ-006 SHALL have port rf_tx_mode  input  1  line code: 0 = NRZ, 1 = Manchester.
REQ-007 SHALL have port rf_power_domain  input  1  transmitter power enable, asynchronous to clk.
REQ-008 SHALL have port rf_tx_data  input  DATA_WIDTH  payload; stable while rf_tx_start is high.
REQ-009 SHALL have port rf_tx_done  output  1  completion acknowledge back to the register file.
REQ-010 SHALL have port tx_out  output  1  serial line data.
REQ-011 SHALL have port tx_en  output  1  line driver enable, high only while a frame is on the line.
REQ-012 SHALL have port tx_busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL synchronise rf_tx_start and rf_power_domain each through a two-flop synchroniser; all internal logic uses only the synchronised copies (start_s, pwr_s).
REQ-014 SHALL implement the states IDLE, PRE, DATA and DONE.
REQ-015 IDLE -> PRE (or DATA when preamble is compiled out) SHALL occur on a start_s rising edge while pwr_s=1; rising edges while pwr_s=0 are ignored and not remembered.
REQ-016 On that transition the block SHALL capture rf_tx_data and rf_tx_mode into internal registers; later input changes do not affect the frame in flight.
REQ-017 Latency: tx_en SHALL go high on the 3rd rising clk edge after rf_tx_start rises, given setup is met at the first synchroniser flop.
REQ-018 Each bit SHALL occupy exactly BIT_CYCLES clk cycles, and bits SHALL be sent MSB-first.
REQ-019 NRZ: tx_out SHALL equal the bit value for the whole bit period.
REQ-020 Manchester: tx_out SHALL be ~bit for the first BIT_CYCLES/2 cycles and bit for the second half.
REQ-021 DATA -> DONE SHALL occur after the last cycle of bit 0; tx_en and tx_out go low on entry to DONE.
REQ-022 In DONE, rf_tx_done SHALL be high and SHALL stay high until start_s=0 (four-phase handshake), then the block returns to IDLE. rf_tx_done is high for at least one cycle even when start_s is already low on entry.
REQ-023 A start_s fall during PRE or DATA SHALL NOT abort the frame.
REQ-024 pwr_s=0 in PRE, DATA or DONE SHALL force IDLE on the next edge: tx_en=0, tx_out=0, rf_tx_done=0, and no done is reported for the aborted frame.
REQ-025 A new frame SHALL start only from IDLE; a start_s that is still high after DONE does not retrigger.
REQ-026 The bit counter SHALL be sized ceil(log2(DATA_WIDTH+1)) and SHALL NOT wrap within a frame.

Reset
REQ-027 resetn=0 SHALL immediately force: state IDLE; tx_out=0, tx_en=0, tx_busy=0, rf_tx_done=0; synchronisers, counters and capture registers cleared. This holds mid-frame.
REQ-028 After resetn deasserts, the block SHALL require a fresh start_s rising edge; a start held high through reset SHALL NOT trigger a frame.

Configuration
REQ-029 Macro RF_TX_PREAMBLE_EN defined: the block SHALL send an 8-bit 0xAA preamble in state PRE before the payload, MSB-first, using the same line code and BIT_CYCLES.
REQ-030 Macro RF_TX_PREAMBLE_EN undefined: state PRE and its logic SHALL be absent, IDLE SHALL go directly to DATA, and the frame length is DATA_WIDTH bits.

Verification
REQ-031 Scenario: preamble off, NRZ, BIT_CYCLES=4, data 0xA5000001, start high -> tx_en high for 128 cycles; tx_out pattern 1010 0101, then zeros, then final bit 1; rf_tx_done rises after that; lowering start drops done 2-3 cycles later.
REQ-032 Scenario: Manchester, data 0x80000000 -> first bit period 0011, remaining 31 periods 1100 each; total 128 tx_en cycles.
REQ-033 Scenario: RF_TX_PREAMBLE_EN defined, NRZ -> 8 bits 10101010 precede the payload; tx_en high for 160 cycles.
REQ-034 Scenario: rf_power_domain dropped at bit 10 -> tx_en=0 within 3 cycles; rf_tx_done never asserts; the next start sends a complete frame.
REQ-035 Scenario: start pulses while rf_power_domain=0, and start held high through resetn release -> no frame is sent; tx_busy stays 0.
REQ-036 Scenario: resetn asserted mid-DATA -> all outputs 0 in the same cycle; rf_tx_data changed mid-frame has no effect on the frame in flight.
